// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 32-bit RAM between the fetch
// stage (read-only) and the memory stage (read/write).
// FSM: IDLE -> ACCESS (RAM req/ack handshake) -> RESP (one-cycle ack).
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin
// arbitration on ties. Without it, the data port has fixed priority.
// All outputs are registered. There is no combinational path from any
// input to any output.

module mem_port_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic              ram_ack,
  input  logic [31:0]       ram_rdata,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  state_t state_r;
  logic   any_req_s;
  logic   pick_dm_s;

  // Winner selection for the next grant. The grant register holds the most
  // recent owner after each access, so it also serves as the round-robin
  // pointer (reset value 0 = "fetch").
  always_comb begin
    any_req_s = if_req | dm_req;
    pick_dm_s = 1'b0;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_dm_s = ~grant;
`else
      pick_dm_s = 1'b1;
`endif
    end else if (dm_req) begin
      pick_dm_s = 1'b1;
    end else begin
      pick_dm_s = 1'b0;
    end
  end

  // Arbitration FSM with all RAM-side and requester-side outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= 32'h0000_0000;
      ram_be    <= 4'b0000;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= 32'h0000_0000;
      dm_rdata  <= 32'h0000_0000;
      grant     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          if (any_req_s) begin
            grant   <= pick_dm_s;
            busy    <= 1'b1;
            ram_req <= 1'b1;
            state_r <= ST_ACCESS;
            if (pick_dm_s) begin
              ram_addr  <= dm_addr;
              ram_we    <= dm_we;
              ram_wdata <= dm_wdata;
              // Reads must never present byte enables to the RAM.
              ram_be    <= dm_we ? dm_be : 4'b0000;
            end else begin
              ram_addr  <= if_addr;
              ram_we    <= 1'b0;
              ram_wdata <= 32'h0000_0000;
              ram_be    <= 4'b0000;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // RAM-side outputs stay frozen until the RAM completes.
          if (ram_ack) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            state_r <= ST_RESP;
            if (grant) begin
              dm_ack <= 1'b1;
              if (!ram_we) begin
                dm_rdata <= ram_rdata;
              end else begin
                dm_rdata <= dm_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          // Requests seen here are stale (owner) or deferred (other port).
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
